// File: rtl/conv_out_writeback.sv
// conv_out_writeback: takes one PE output vector per output pixel from the
// systolic array, optionally applies ReLU, and writes the first valid_cols
// words into the feature-map BRAM one word per cycle in channel-major layout
// (address = base + (och + col) * plane_size + pix). Pulses finish once the
// whole pass has been written.
module conv_out_writeback #(
  parameter int width      = 16,
  parameter int decimal    = 12,
  parameter int cols       = 4,
  parameter int memaddrbit = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    relu,
  input  logic [memaddrbit-1:0]   base_addr,
  input  logic [memaddrbit-1:0]   och,
  input  logic [memaddrbit-1:0]   plane_size,
  input  logic [memaddrbit-1:0]   num_pixels,
  input  logic [2:0]              valid_cols,
  input  logic [cols*width-1:0]   outs_array,
  input  logic                    vec_valid,
  output logic                    vec_ready,
  output logic                    wea_w,
  output logic [memaddrbit-1:0]   memaddr,
  output logic [width-1:0]        mem_in,
  output logic                    busy,
  output logic                    finish
);

  // The sign bit sits at width-1, so the fixed-point split must leave room for it.
  if (decimal >= width) begin : g_bad_decimal
    $error("conv_out_writeback: decimal must be smaller than width");
  end

  localparam int cw = $clog2(cols + 1);

  typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

  state_t                  state;
  state_t                  next_state;
  logic                    relu_r;
  logic [memaddrbit-1:0]   ch0_base;
  logic [memaddrbit-1:0]   plane_r;
  logic [memaddrbit-1:0]   np_r;
  logic [memaddrbit-1:0]   pix;
  logic [cw-1:0]           vc_r;
  logic [cw-1:0]           col;
  logic [cols*width-1:0]   vec_sh;
  logic                    last_col;
  logic                    last_pix;

  // ReLU is a pure sign test: negative words become zero.
  function automatic logic [width-1:0] relu_word(input logic en, input logic [width-1:0] w);
    return (en && w[width-1]) ? '0 : w;
  endfunction

  assign last_col = (col == vc_r - cw'(1));
  assign last_pix = (pix == np_r - memaddrbit'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic: a vector is taken in WAIT, drained in WRITE, and the
  // pass ends through DONE so finish is a single-cycle pulse.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (num_pixels == '0) ? DONE : WAIT;
      WAIT:    if (vec_valid) next_state = WRITE;
      WRITE:   if (last_col) next_state = last_pix ? DONE : WAIT;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control outputs decode straight from the state register.
  always_comb begin
    vec_ready = (state == WAIT);
    wea_w     = (state == WRITE);
    busy      = (state != IDLE);
    finish    = (state == DONE);
  end

  // Datapath: memaddr/mem_in are loaded one edge ahead of the WRITE cycle that
  // presents them. memaddr doubles as the running address, stepping by one
  // channel plane per column; the captured vector is shifted so the next
  // column always sits in the low word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      relu_r   <= 1'b0;
      ch0_base <= '0;
      plane_r  <= '0;
      np_r     <= '0;
      vc_r     <= '0;
      pix      <= '0;
      col      <= '0;
      vec_sh   <= '0;
      memaddr  <= '0;
      mem_in   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            relu_r   <= relu;
            ch0_base <= base_addr + och * plane_size;
            plane_r  <= plane_size;
            np_r     <= num_pixels;
            vc_r     <= (valid_cols == 3'd0 || int'(valid_cols) > cols) ? cw'(cols) : cw'(valid_cols);
            pix      <= '0;
            col      <= '0;
          end
        end
        WAIT: begin
          if (vec_valid) begin
            vec_sh  <= outs_array >> width;
            mem_in  <= relu_word(relu_r, outs_array[width-1:0]);
            memaddr <= ch0_base + pix;
            col     <= '0;
          end
        end
        WRITE: begin
          if (last_col) begin
            if (!last_pix) pix <= pix + memaddrbit'(1);
          end else begin
            col     <= col + cw'(1);
            memaddr <= memaddr + plane_r;
            mem_in  <= relu_word(relu_r, vec_sh[width-1:0]);
            vec_sh  <= vec_sh >> width;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_out_writeback.sv
// Self-checking bench for conv_out_writeback. Writes and finish pulses are
// recorded by monitors and compared against a list of expected BRAM writes
// computed directly from the address/ReLU rules.
module tb_conv_out_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        relu;
  logic [19:0] base_addr;
  logic [19:0] och;
  logic [19:0] plane_size;
  logic [19:0] num_pixels;
  logic [2:0]  valid_cols;
  logic [63:0] outs_array;
  logic        vec_valid;
  logic        vec_ready;
  logic        wea_w;
  logic [19:0] memaddr;
  logic [15:0] mem_in;
  logic        busy;
  logic        finish;

  // Free-running clock.
  always #5 clk = ~clk;

  conv_out_writeback #(.width(16), .decimal(12), .cols(4), .memaddrbit(20)) dut (
    .clk(clk), .rst(rst), .start(start), .relu(relu), .base_addr(base_addr),
    .och(och), .plane_size(plane_size), .num_pixels(num_pixels),
    .valid_cols(valid_cols), .outs_array(outs_array), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .wea_w(wea_w), .memaddr(memaddr), .mem_in(mem_in),
    .busy(busy), .finish(finish)
  );

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         obs_q[$];
  wr_t         exp_q[$];
  int          acc_q[$];
  int          fin_q[$];
  logic [63:0] vec_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          start_cyc;
  logic        busy_after;

  // Count cycles and note the cycle in which each accepted vector's first write should appear.
  always @(posedge clk) begin
    if (rst === 1'b1 && vec_ready === 1'b1 && vec_valid === 1'b1) acc_q.push_back(cyc + 1);
    cyc = cyc + 1;
  end

  // Record every BRAM write and finish pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wea_w === 1'b1) obs_q.push_back('{memaddr, mem_in, cyc});
    if (finish === 1'b1) fin_q.push_back(cyc);
  end

  // Global time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference model: every write of a pass, straight from the address formula.
  task automatic build_expected(input logic rl, input logic [19:0] b, input logic [19:0] o,
                                input logic [19:0] ps, input logic [19:0] np, input logic [2:0] vc);
    int                vce;
    longint unsigned   a;
    logic [15:0]       w;
    exp_q.delete();
    vce = (vc == 3'd0 || vc > 3'd4) ? 4 : int'(vc);
    for (int p = 0; p < int'(np); p++) begin
      for (int c = 0; c < vce; c++) begin
        w = vec_q[p][c*16 +: 16];
        a = longint'(b) + (longint'(o) + longint'(c)) * longint'(ps) + longint'(p);
        exp_q.push_back('{a[19:0], (rl && w[15]) ? 16'h0000 : w, 0});
      end
    end
  endtask

  // Drive one complete pass; configuration inputs are scrambled after start.
  task automatic run_pass(input logic rl, input logic [19:0] b, input logic [19:0] o,
                          input logic [19:0] ps, input logic [19:0] np, input logic [2:0] vc,
                          input int min_gap, input int max_gap, input bit poke_start);
    int n;
    obs_q.delete(); acc_q.delete(); fin_q.delete();
    build_expected(rl, b, o, ps, np, vc);
    relu = rl; base_addr = b; och = o; plane_size = ps; num_pixels = np; valid_cols = vc;
    start = 1'b1; start_cyc = cyc;
    step();
    start = 1'b0;
    relu = 1'($urandom); base_addr = 20'($urandom); och = 20'($urandom);
    plane_size = 20'($urandom); num_pixels = 20'($urandom); valid_cols = 3'($urandom);
    if (poke_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int p = 0; p < int'(np); p++) begin
      repeat ($urandom_range(max_gap, min_gap)) begin
        outs_array = {$urandom, $urandom};
        step();
      end
      outs_array = vec_q[p];
      vec_valid = 1'b1;
      n = 0;
      while (vec_ready !== 1'b1 && n < 200) begin step(); n++; end
      step();
      vec_valid = 1'b0;
      outs_array = {$urandom, $urandom};
    end
    n = 0;
    while (fin_q.size() == 0 && n < 100) begin step(); n++; end
    step();
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; vec_valid = 1'b1; outs_array = 64'hFFFF_FFFF_FFFF_FFFF;
    relu = 1'b0; base_addr = 20'h1; och = 20'h1; plane_size = 20'h1; num_pixels = 20'h1; valid_cols = 3'd4;
    step(); step();
    checks++; if (wea_w !== 1'b0)      begin errors++; $display("[TB] FAIL reset_wea_w got %b want 0", wea_w); end
    checks++; if (vec_ready !== 1'b0)  begin errors++; $display("[TB] FAIL reset_vec_ready got %b want 0", vec_ready); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (finish !== 1'b0)     begin errors++; $display("[TB] FAIL reset_finish got %b want 0", finish); end
    checks++; if (memaddr !== 20'h0)   begin errors++; $display("[TB] FAIL reset_memaddr got %h want 0", memaddr); end
    checks++; if (mem_in !== 16'h0)    begin errors++; $display("[TB] FAIL reset_mem_in got %h want 0", mem_in); end
    rst = 1'b1; start = 1'b0; vec_valid = 1'b0;
    step();
  endtask

  task automatic test_basic();
    vec_q = '{64'h4000_3000_2000_1000, 64'h0004_0003_0002_0001};
    run_pass(1'b0, 20'h100, 20'h0, 20'd16, 20'd2, 3'd4, 0, 0, 1'b0);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        errors++; $display("[TB] FAIL basic_write%0d got %h/%h want %h/%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
      checks++;
      if (i / 4 >= acc_q.size() || obs_q[i].cyc != acc_q[i / 4] + i % 4) begin
        errors++; $display("[TB] FAIL basic_timing%0d got cycle %0d want accept+%0d", i, obs_q[i].cyc, i % 4);
      end
    end
    checks++;
    if (fin_q.size() != 1 || obs_q.size() == 0 || fin_q[0] != obs_q[obs_q.size()-1].cyc + 1) begin
      errors++; $display("[TB] FAIL basic_finish got %0d pulses want 1 right after last write", fin_q.size());
    end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after got %b want 0", busy_after); end
  endtask

  task automatic test_relu();
    for (int k = 0; k < 2; k++) begin
      vec_q = '{64'h7FFF_8000_0800_F000};
      run_pass(k == 0, 20'h0, 20'h0, 20'd1, 20'd1, 3'd4, 0, 2, 1'b0);
      checks++; if (obs_q.size() != 4) begin errors++; $display("[TB] FAIL relu%0d_count got %0d want 4", k, obs_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
          errors++; $display("[TB] FAIL relu%0d_write%0d got %h/%h want %h/%h", k, i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
        end
      end
    end
  endtask

  task automatic test_partial();
    bit leaked;
    vec_q = '{64'hA5A5_5A5A_2222_1111};
    run_pass(1'b0, 20'h0, 20'd6, 20'd9, 20'd1, 3'd2, 0, 1, 1'b0);
    checks++; if (obs_q.size() != 2) begin errors++; $display("[TB] FAIL partial_count got %0d want 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        errors++; $display("[TB] FAIL partial_write%0d got %h/%h want %h/%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    leaked = 1'b0;
    foreach (obs_q[i]) if (obs_q[i].data == 16'h5A5A || obs_q[i].data == 16'hA5A5) leaked = 1'b1;
    checks++; if (leaked) begin errors++; $display("[TB] FAIL partial_discard got column 2/3 data written want none"); end
    checks++; if (fin_q.size() != 1) begin errors++; $display("[TB] FAIL partial_finish got %0d pulses want 1", fin_q.size()); end
  endtask

  task automatic test_zero_pixels();
    vec_q.delete();
    run_pass(1'b0, 20'h55, 20'h1, 20'h4, 20'd0, 3'd4, 0, 0, 1'b0);
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL zero_pixels_writes got %0d want 0", obs_q.size()); end
    checks++;
    if (fin_q.size() != 1 || fin_q[0] != start_cyc + 1) begin
      errors++; $display("[TB] FAIL zero_pixels_finish got %0d pulses want 1 at cycle %0d", fin_q.size(), start_cyc + 1);
    end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("[TB] FAIL zero_pixels_busy got %b want 0", busy_after); end
  endtask

  task automatic test_start_while_busy();
    vec_q = '{64'h0D0C_0B0A_0908_0706};
    run_pass(1'b0, 20'h300, 20'd1, 20'd5, 20'd1, 3'd4, 2, 2, 1'b1);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL busy_start_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        errors++; $display("[TB] FAIL busy_start_write%0d got %h/%h want %h/%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++; if (fin_q.size() != 1) begin errors++; $display("[TB] FAIL busy_start_finish got %0d pulses want 1", fin_q.size()); end
  endtask

  task automatic test_stall();
    vec_q = '{64'h1004_1003_1002_1001, 64'h2004_2003_2002_2001};
    run_pass(1'b0, 20'h50, 20'd1, 20'd3, 20'd2, 3'd4, 10, 10, 1'b0);
    checks++; if (obs_q.size() != 8) begin errors++; $display("[TB] FAIL stall_count got %0d want 8", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        errors++; $display("[TB] FAIL stall_write%0d got %h/%h want %h/%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (acc_q.size() != 2 || acc_q[1] - acc_q[0] < 11 || obs_q.size() < 5 || obs_q[4].cyc != acc_q[1]) begin
      errors++; $display("[TB] FAIL stall_resume got %0d accepts want 2 with writes resuming on accept", acc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    obs_q.delete(); acc_q.delete(); fin_q.delete();
    relu = 1'b0; base_addr = 20'h40; och = 20'h0; plane_size = 20'd8; num_pixels = 20'd1; valid_cols = 3'd4;
    start = 1'b1; step(); start = 1'b0;
    outs_array = 64'h4444_3333_2222_1111; vec_valid = 1'b1;
    n = 0;
    while (vec_ready !== 1'b1 && n < 50) begin step(); n++; end
    step();
    vec_valid = 1'b0;
    n = 0;
    while (obs_q.size() < 2 && n < 50) begin step(); n++; end
    rst = 1'b0;
    step();
    checks++; if (wea_w !== 1'b0) begin errors++; $display("[TB] FAIL midreset_wea_w got %b want 0", wea_w); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
    checks++; if (memaddr !== 20'h0) begin errors++; $display("[TB] FAIL midreset_memaddr got %h want 0", memaddr); end
    rst = 1'b1;
    repeat (8) step();
    checks++; if (obs_q.size() != 2) begin errors++; $display("[TB] FAIL midreset_writes got %0d want 2", obs_q.size()); end
    checks++; if (fin_q.size() != 0) begin errors++; $display("[TB] FAIL midreset_finish got %0d pulses want 0", fin_q.size()); end
    vec_q = '{64'h8888_7777_6666_5555};
    run_pass(1'b0, 20'h200, 20'd0, 20'd8, 20'd1, 3'd4, 0, 1, 1'b0);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL midreset_restart_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        errors++; $display("[TB] FAIL midreset_restart%0d got %h/%h want %h/%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_random();
    logic        rl;
    logic [19:0] b, o, ps, np;
    logic [2:0]  vc;
    int          vce;
    for (int t = 0; t < 10; t++) begin
      rl = 1'($urandom); b = 20'($urandom); o = 20'($urandom); ps = 20'($urandom);
      np = 20'($urandom_range(4, 1)); vc = 3'($urandom_range(7, 0));
      vce = (vc == 3'd0 || vc > 3'd4) ? 4 : int'(vc);
      vec_q.delete();
      for (int p = 0; p < int'(np); p++) vec_q.push_back({$urandom, $urandom});
      run_pass(rl, b, o, ps, np, vc, 0, 3, 1'b0);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rand%0d_count got %0d want %0d", t, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
          errors++; $display("[TB] FAIL rand%0d_write%0d got %h/%h want %h/%h", t, i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
        end
        checks++;
        if (i / vce >= acc_q.size() || obs_q[i].cyc != acc_q[i / vce] + i % vce) begin
          errors++; $display("[TB] FAIL rand%0d_timing%0d got cycle %0d want accept+%0d", t, i, obs_q[i].cyc, i % vce);
        end
      end
      checks++;
      if (fin_q.size() != 1 || obs_q.size() == 0 || fin_q[0] != obs_q[obs_q.size()-1].cyc + 1) begin
        errors++; $display("[TB] FAIL rand%0d_finish got %0d pulses want 1 right after last write", t, fin_q.size());
      end
      checks++; if (busy_after !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_busy_after got %b want 0", t, busy_after); end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_partial();
    test_zero_pixels();
    test_start_while_busy();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_out_writeback.md
Name: conv_out_writeback

Overview:
- Downstream of the systolic array: consumes each output vector (cols PE results, one per output channel) for one output pixel.
- Optionally applies ReLU, then serialises the vector into the feature-map BRAM, one word per cycle, in channel-major layout.
- Raises a one-cycle finish pulse when the whole picture is written, so the max-pooling stage or the layer sequencer can proceed.

Parameters:
width, 16, data word width (signed fixed point)
decimal, 12, fractional bits (informational; ReLU is a sign test only)
cols, 4, words per output vector / PE columns
memaddrbit, 20, BRAM address width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; sampled only in IDLE
relu  in  1  ReLU enable, latched on start
base_addr  in  memaddrbit  output feature-map base address, latched on start
och  in  memaddrbit  output channel of column 0, latched on start
plane_size  in  memaddrbit  dr_out*dc_out, words per channel plane, latched on start
num_pixels  in  memaddrbit  vectors to write this pass, latched on start
valid_cols  in  3  columns written per vector (1..cols; 0 or >cols treated as cols), latched on start
outs_array  in  cols*width  output vector; column j at bits [j*width +: width]
vec_valid  in  1  outs_array holds a valid vector
vec_ready  out  1  block accepts the vector this cycle
wea_w  out  1  BRAM write enable
memaddr  out  memaddrbit  BRAM write address
mem_in  out  width  BRAM write data
busy  out  1  high in every state except IDLE
finish  out  1  one-cycle done pulse

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - vec_ready, wea_w, busy and finish are 0; memaddr and mem_in are 0.
  - Captured vector and counters are cleared.
  - Applies mid-operation too: no further writes after the reset edge, and no finish.
- All outputs are registered.
- State machine:
  - IDLE → on start:
    - Latch all configuration inputs.
    - pix := 0, col := 0.
    - If num_pixels == 0, go to DONE; otherwise go to WAIT.
  - WAIT:
    - vec_ready = 1 (combinational from state).
    - On vec_valid & vec_ready: capture outs_array, col := 0, go to WRITE.
  - WRITE, one write per cycle (outputs visible in the cycle after the edge):
    - wea_w = 1.
    - memaddr = base_addr + (och + col)*plane_size + pix, truncated to memaddrbit bits (wrap silently).
    - mem_in = (relu && word[col][width-1]) ? 0 : word[col].
    - col increments after each write.
    - After the write with col == valid_cols-1:
      - If pix == num_pixels-1, go to DONE.
      - Otherwise pix := pix+1 and go to WAIT.
  - DONE: finish = 1 for exactly one cycle, wea_w = 0, then IDLE.
- Columns at or above valid_cols are discarded; they are never written.
- Timing:
  - Latency: vector accepted at edge N; the first write is presented in cycle N+1 and the last in cycle N+valid_cols.
  - Throughput: one vector per valid_cols+1 cycles.
  - finish is asserted in the cycle after the last write.
- start outside IDLE is ignored; configuration does not change mid-pass.
- vec_valid outside WAIT is ignored. The upstream stage must hold the vector until vec_ready.
- wea_w is never high outside WRITE; memaddr and mem_in hold their last values when wea_w = 0.
- A multiplier is optional. A running address (channel stride accumulator plus pixel offset) is an acceptable implementation, provided results equal the formula above.

Test Plan:
1. Reset: drive rst=0 for 2 cycles with start=1 and vec_valid=1 → wea_w=0, vec_ready=0, busy=0, finish=0, memaddr=0, mem_in=0.
2. Basic pass:
   - Config: base_addr=0x100, och=0, plane_size=16, num_pixels=2, valid_cols=4, relu=0.
   - Vectors: {col0..3} = {0x1000, 0x2000, 0x3000, 0x4000}, then {0x0001, 0x0002, 0x0003, 0x0004}.
   - Required writes: 0x100, 0x110, 0x120, 0x130 with data 0x1000..0x4000, then 0x101, 0x111, 0x121, 0x131 with data 0x0001..0x0004.
   - finish one cycle after the last write, then busy=0.
3. ReLU:
   - relu=1, vector {0xF000, 0x0800, 0x8000, 0x7FFF} → mem_in 0x0000, 0x0800, 0x0000, 0x7FFF.
   - Same vector with relu=0 → written unchanged.
4. Partial group and offset:
   - Config: valid_cols=2, och=6, plane_size=9, base_addr=0, num_pixels=1.
   - Required: exactly two writes, at addresses 54 and 63.
   - Columns 2 and 3 never appear on mem_in; finish follows.
5. Edge cases:
   - num_pixels=0 → no wea_w pulse; finish high in the cycle after the start edge.
   - Second start while busy → ignored.
   - vec_valid held low in WAIT for 10 cycles → no writes; writes resume on the first valid.
6. Reset mid-WRITE:
   - Assert rst=0 after the 2nd write of a 4-column vector → wea_w=0 from that edge, state IDLE, no finish.
   - A new start with base_addr=0x200 then writes from 0x200 correctly.
